// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, TX FIFO, 8N1 framing.
// Optional even parity bit (8E1 framing) is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_tx_o,
  output logic        tx_idle_o
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX    = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic        PAR_PRESENT = 1'b1;
`else
  localparam logic        PAR_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   baud, baud_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_q, tx_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full, empty;
  logic          sel_data, sel_status;
  logic          push_req, push, pop, ovf_set, ovf_clr;
  logic [31:0]   status;
  logic          unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  assign sel_data   = (bus_addr == BASE_ADDR);
  assign sel_status = (bus_addr == STATUS_ADDR);
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign pop        = (state == IDLE) && !empty;
  assign push_req   = bus_wen && sel_data;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!full || pop);
  assign ovf_set    = push_req && !push;
  assign ovf_clr    = bus_wen && sel_status && bus_wdata[3];

  assign tx_idle_o  = empty && (state == IDLE);
  assign uart_tx_o  = tx_q;

  always_comb begin
    status       = '0;
    status[0]    = (state != IDLE);
    status[1]    = full;
    status[2]    = empty;
    status[3]    = overflow;
    status[4]    = PAR_PRESENT;
    status[14:8] = 7'(count);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (bus_ren) bus_rdata <= sel_status ? status : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= idx_n;
      shreg   <= sh_n;
      tx_q    <= tx_n;
    end
  end

  // Baud counter counts down to zero; every bit boundary reloads it.
  always_comb begin
    state_n = state;
    baud_n  = (baud == '0) ? BAUD_MAX : baud - 1'b1;
    idx_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        baud_n = baud;
        if (!empty) begin
          sh_n    = mem[rd_ptr];
          baud_n  = BAUD_MAX;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud == '0) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shreg[bit_idx];
        if (baud == '0) begin
          idx_n = bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx == 3'd7) state_n = PARITY;
`else
          if (bit_idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = ^shreg;
        if (baud == '0) state_n = STOP;
      end
`endif
      STOP: begin
        if (baud == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
